// File: rtl/dff_pkg.sv
// Shared definitions for the set/reset D register family: width limit and load-source selection.
package dff_pkg;

  localparam int unsigned DFF_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    LD_RESET,
    LD_SET,
    LD_DATA,
    LD_HOLD
  } ld_src_e;

  // Fixed priority: reset over set over data load over hold.
  function automatic ld_src_e ld_select(input logic reset, input logic set, input logic en);
    ld_src_e src;
    if (reset)    src = LD_RESET;
    else if (set) src = LD_SET;
    else if (en)  src = LD_DATA;
    else          src = LD_HOLD;
    return src;
  endfunction

endpackage

// File: rtl/dff_bit_cell.sv
// Single-bit register with synchronous reset, set and load enable.
module dff_bit_cell
  import dff_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0,
  parameter logic SET_VAL   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic en,
  input  logic d,
  output logic q
);

  ld_src_e ld_src;
  logic    q_next;

  // Priority mux selecting the value captured on the next edge.
  always_comb begin
    ld_src = ld_select(reset, set, en);
    q_next = q;
    case (ld_src)
      LD_RESET: q_next = RESET_VAL;
      LD_SET:   q_next = SET_VAL;
      LD_DATA:  q_next = d;
      LD_HOLD:  q_next = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) q <= RESET_VAL;
    else       q <= q_next;
  end

endmodule

// File: rtl/dff_set_reset.sv
// WIDTH-bit D register with complementary outputs and synchronous set/reset.
// Define DFF_SET_RESET_ASSERT_EN to compile in simulation-only input/output checks.
module dff_set_reset
  import dff_pkg::*;
#(
  parameter int unsigned          WIDTH     = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0,
  parameter logic [WIDTH-1:0]     SET_VAL   = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  // One cell per bit; each gets its own slice of the reset/set constants.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_bit_cell #(
      .RESET_VAL(RESET_VAL[i]),
      .SET_VAL  (SET_VAL[i])
    ) u_cell (
      .clk  (clk),
      .reset(reset),
      .set  (set),
      .en   (en),
      .d    (d[i]),
      .q    (q[i])
    );
  end

  assign qbar = ~q;

`ifdef DFF_SET_RESET_ASSERT_EN
  always @(posedge clk) begin
    assert (!$isunknown({reset, set}))
      else $error("dff_set_reset: set/reset unknown at clk edge");
    if (reset && set)
      $warning("dff_set_reset: set and reset both asserted, reset wins");
  end

  always_comb begin
    assert (qbar === ~q)
      else $error("dff_set_reset: qbar is not the complement of q");
  end
`else
`endif

endmodule

// File: tb/tb_dff_set_reset.sv
// Directed plus random checks of dff_set_reset at WIDTH=1 and WIDTH=8 (RESET_VAL=8'h5A).
module tb_dff_set_reset;

  logic       clk = 1'b0;
  logic       reset, set, en;
  logic       d1;
  logic       q1, qbar1;
  logic [7:0] d8, q8, qbar8;

  logic       qe1;
  logic [7:0] qe8;
  int         n_assert = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  dff_set_reset #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .set(set), .en(en), .d(d1), .q(q1), .qbar(qbar1)
  );

  dff_set_reset #(.WIDTH(8), .RESET_VAL(8'h5A)) dut8 (
    .clk(clk), .reset(reset), .set(set), .en(en), .d(d8), .q(q8), .qbar(qbar8)
  );

  // Reference behaviour: reset beats set beats enabled load, otherwise hold.
  function automatic logic [7:0] ref_next(input logic [7:0] cur, input logic r, input logic s,
                                          input logic e, input logic [7:0] dv,
                                          input logic [7:0] rv, input logic [7:0] sv);
    if (r) return rv;
    if (s) return sv;
    if (e) return dv;
    return cur;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q1"},    {7'b0, q1},    {7'b0, qe1});
    chk({tag, ".qbar1"}, {7'b0, qbar1}, {7'b0, ~qe1});
    chk({tag, ".q8"},    q8,            qe8);
    chk({tag, ".qbar8"}, qbar8,         ~qe8);
  endtask

  task automatic drive(input logic r, input logic s, input logic e,
                       input logic dd1, input logic [7:0] dd8);
    reset = r; set = s; en = e; d1 = dd1; d8 = dd8;
  endtask

  // Advance to the next rising edge, update the model, check at edge+1, drive point at edge+3.
  task automatic tick(input string tag);
    logic [7:0] n1;
    @(posedge clk);
    n1  = ref_next({7'b0, qe1}, reset, set, en, {7'b0, d1}, 8'h00, 8'h01);
    qe1 = n1[0];
    qe8 = ref_next(qe8, reset, set, en, d8, 8'h5A, 8'hFF);
    #1;
    check_all(tag);
    #2;
  endtask

  initial begin
    logic bits [5];
    bits[0] = 1'b1; bits[1] = 1'b0; bits[2] = 1'b1; bits[3] = 1'b1; bits[4] = 1'b0;
    qe1 = 1'b0;
    qe8 = 8'h00;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick("reset");

    // Basic capture: d1 = 1,0,1,1,0 driven at 8/18/28/38/48 ns.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b1, bits[i], 8'($urandom));
      tick("capture");
    end

    // Reset asserted between edges takes effect only at the next edge.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h3C);
    tick("pre_reset");
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'hC3);
    #1 check_all("reset_mid");
    tick("reset_edge");
    tick("reset_held1");
    tick("reset_held2");

    // One-cycle set pulse, then data resumes.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    tick("pre_set");
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    tick("set_pulse");
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h11);
    tick("after_set");

    // Simultaneous set and reset: reset wins; then set alone.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h77);
    tick("set_and_reset");
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h77);
    tick("set_only");

    // Enable hold on the 8-bit instance.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
    tick("en_reset");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
    tick("en_hold1");
    tick("en_hold2");
    tick("en_hold3");
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'hFF);
    tick("en_load");

    // 2 ns set and reset glitches entirely between edges.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    set = 1'b1; #2 set = 1'b0;
    #1 check_all("glitch_set_mid");
    tick("glitch_set");
    reset = 1'b1; #2 reset = 1'b0;
    #1 check_all("glitch_reset_mid");
    tick("glitch_reset");

    // Random stimulus against the reference model.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(7) == 0), ($urandom_range(7) == 0), 1'($urandom),
            1'($urandom), 8'($urandom));
      tick("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
